// File: rtl/ifu_if.sv
// Fetch-side bundle of the instruction fetch unit: instruction-memory request/response
// plus the valid/ready handshake towards decode. master = ifu, slave = memory/decode side.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

interface ifu_if;
    logic                     o_ifu_ram_req_valid;
    logic                     i_ram_req_ready;
    logic [`ADDR_WIDTH-1:0]   o_ifu_ram_addr;
    logic                     i_ram_rsp_valid;
    logic [`INST_WIDTH-1:0]   i_ram_inst;
    logic                     o_sys_valid;
    logic                     i_sys_ready;
    logic [`INST_WIDTH-1:0]   o_ifu_inst;
    logic [`ADDR_WIDTH-1:0]   o_ifu_pc;

    modport master (
        output o_ifu_ram_req_valid, o_ifu_ram_addr, o_sys_valid, o_ifu_inst, o_ifu_pc,
        input  i_ram_req_ready, i_ram_rsp_valid, i_ram_inst, i_sys_ready
    );

    modport slave (
        input  o_ifu_ram_req_valid, o_ifu_ram_addr, o_sys_valid, o_ifu_inst, o_ifu_pc,
        output i_ram_req_ready, i_ram_rsp_valid, i_ram_inst, i_sys_ready
    );
endinterface

// File: rtl/ifu.sv
// Instruction fetch stage: one outstanding fetch, buffered word presented to decode.
// Optional IFU_ALIGN_CHK_EN: misaligned redirect targets raise a sticky error and halt.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module ifu #(
    parameter logic [`ADDR_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_rst_n,
    ifu_if.master                  bus,
    input  logic                   i_exu_jmp_en,
    input  logic [`ADDR_WIDTH-1:0] i_exu_jmp_pc,
    input  logic                   i_idu_end_flag,
    output logic                   o_ifu_halt,
    output logic                   o_ifu_misalign
);
    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_HOLD, S_HALT
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [`ADDR_WIDTH-1:0] r_pc;
    logic [`INST_WIDTH-1:0] r_inst;
    logic                   r_kill;

    logic                   w_active;
    logic                   w_jmp;
    logic                   w_jmp_bad;
    logic                   w_jmp_ok;
    logic                   w_fire;
    logic                   w_rsp;
    logic [`ADDR_WIDTH-1:0] w_jmp_tgt;

    assign w_active = (r_state == S_REQ) || (r_state == S_WAIT) || (r_state == S_HOLD);
    assign w_jmp    = i_exu_jmp_en && w_active;
    assign w_fire   = (r_state == S_REQ) && bus.i_ram_req_ready;
    assign w_rsp    = (r_state == S_WAIT) && bus.i_ram_rsp_valid;
    assign w_jmp_ok = w_jmp && !w_jmp_bad;

`ifdef IFU_ALIGN_CHK_EN
    logic r_misalign;

    assign w_jmp_bad = w_jmp && (i_exu_jmp_pc[1:0] != 2'b00);
    assign w_jmp_tgt = i_exu_jmp_pc;

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n)   r_misalign <= 1'b0;
        else if (w_jmp_bad) r_misalign <= 1'b1;
    end

    assign o_ifu_misalign = r_misalign;
`else
    assign w_jmp_bad      = 1'b0;
    assign w_jmp_tgt      = i_exu_jmp_pc & ~`ADDR_WIDTH'(3);
    assign o_ifu_misalign = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would make results depend on statement order.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) r_state <= S_IDLE;
        else              r_state <= w_next;
    end

    // NOTE: every combinational output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: w_next = S_REQ;
            S_REQ:  if (w_fire) w_next = S_WAIT;
            S_WAIT: if (bus.i_ram_rsp_valid) w_next = (r_kill || w_jmp) ? S_REQ : S_HOLD;
            S_HOLD: begin
                if (w_jmp)                 w_next = S_REQ;
                else if (bus.i_sys_ready)  w_next = i_idu_end_flag ? S_HALT : S_REQ;
            end
            S_HALT: w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
        if (w_jmp_bad) w_next = S_HALT;
    end

    always_comb begin
        bus.o_ifu_ram_req_valid = (r_state == S_REQ);
        bus.o_sys_valid         = (r_state == S_HOLD);
        o_ifu_halt              = (r_state == S_HALT);
    end

    // NOTE: the instruction buffer is a single word, so it is cheap to reset and
    // gives decode a known value; larger storage arrays would be left unreset.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_pc   <= RESET_PC;
            r_kill <= 1'b0;
            r_inst <= '0;
        end else begin
            if (w_jmp_ok)
                r_pc <= w_jmp_tgt;
            else if ((r_state == S_HOLD) && bus.i_sys_ready)
                r_pc <= r_pc + `ADDR_WIDTH'(4);

            // kill marks an in-flight fetch whose response belongs to the old stream
            if (w_rsp)
                r_kill <= 1'b0;
            else if (w_jmp_ok && ((r_state == S_WAIT) || w_fire))
                r_kill <= 1'b1;

            if (w_rsp && !r_kill && !w_jmp)
                r_inst <= bus.i_ram_inst;
        end
    end

    assign bus.o_ifu_ram_addr = r_pc;
    assign bus.o_ifu_pc       = r_pc;
    assign bus.o_ifu_inst     = r_inst;
endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed test-plan steps, then randomized traffic
// against a transaction-level model of the architectural PC stream.
module tb_ifu;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        jmp_en;
    logic [31:0] jmp_pc;
    logic        end_flag;
    logic        halt;
    logic        misalign;

    ifu_if bus ();

    ifu #(.RESET_PC(RESET_PC)) dut (
        .i_sys_clk      (clk),
        .i_sys_rst_n    (rst_n),
        .bus            (bus),
        .i_exu_jmp_en   (jmp_en),
        .i_exu_jmp_pc   (jmp_pc),
        .i_idu_end_flag (end_flag),
        .o_ifu_halt     (halt),
        .o_ifu_misalign (misalign)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;

    // reference model state
    logic [31:0] exp_pc;
    bit          halted;
    bit          exp_mis;
    bit          busy;
    int          lat_cnt;
    logic [31:0] busy_addr;
    bit          was_hold;
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;

    // outputs sampled in the most recent cycle
    bit          s_req;
    bit          s_sv;
    logic [31:0] s_addr;
    logic [31:0] s_pc;
    logic [31:0] s_inst;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_pc   = RESET_PC;
        halted   = 1'b0;
        exp_mis  = 1'b0;
        busy     = 1'b0;
        lat_cnt  = 0;
        was_hold = 1'b0;
    endtask

    task automatic drive_idle();
        bus.i_ram_req_ready = 1'b0;
        bus.i_ram_rsp_valid = 1'b0;
        bus.i_ram_inst      = '0;
        bus.i_sys_ready     = 1'b0;
        jmp_en              = 1'b0;
        jmp_pc              = '0;
        end_flag            = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        drive_idle();
        #1;
        check("rst_async_req", bus.o_ifu_ram_req_valid, 1'b0);
        check("rst_async_valid", bus.o_sys_valid, 1'b0);
        check("rst_async_halt", halt, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_addr", bus.o_ifu_ram_addr, RESET_PC);
        check("rst_pc", bus.o_ifu_pc, RESET_PC);
        check("rst_inst", bus.o_ifu_inst, 32'h0);
        check("rst_misalign", misalign, 1'b0);
        rst_n = 1'b1;
        // stray response during the IDLE cycle must be ignored
        bus.i_ram_rsp_valid = 1'b1;
        bus.i_ram_inst      = 32'hBAD0_BAD0;
        model_clear();
        #1;
        check("idle_no_req", bus.o_ifu_ram_req_valid, 1'b0);
    endtask

    // One clock cycle: sample outputs, drive inputs, check and advance the model.
    task automatic cyc(input bit rdy, input int lat, input bit srdy, input bit jen,
                       input logic [31:0] jpc, input bit endf, input bit stray);
        bit rsp;
        bit fire;
        bit hs;
        @(negedge clk);
        s_req  = bus.o_ifu_ram_req_valid;
        s_sv   = bus.o_sys_valid;
        s_addr = bus.o_ifu_ram_addr;
        s_pc   = bus.o_ifu_pc;
        s_inst = bus.o_ifu_inst;

        check("halt", halt, halted);
        check("misalign", misalign, exp_mis);
        if (halted) begin
            check("halt_no_req", s_req, 1'b0);
            check("halt_no_valid", s_sv, 1'b0);
        end
        if (s_req) begin
            check("one_outstanding", busy, 1'b0);
            check("addr_aligned", s_addr & 32'h3, 32'h0);
        end
        if (was_hold && s_sv) begin
            check("hold_pc_stable", s_pc, hold_pc);
            check("hold_inst_stable", s_inst, hold_inst);
        end

        rsp = busy && (lat_cnt == 0);
        bus.i_ram_req_ready = rdy;
        bus.i_ram_rsp_valid = rsp || (stray && s_req);
        bus.i_ram_inst      = rsp ? mem_word(busy_addr) : $urandom;
        bus.i_sys_ready     = srdy;
        jmp_en              = jen;
        jmp_pc              = jpc;
        end_flag            = endf;

        fire = s_req && rdy;
        hs   = s_sv && srdy;
        if (fire && !jen) check("req_addr", s_addr, exp_pc);
        if (hs && !jen) begin
            check("dec_pc", s_pc, exp_pc);
            check("dec_inst", s_inst, mem_word(exp_pc));
        end

        was_hold  = s_sv && !srdy && !jen;
        hold_pc   = s_pc;
        hold_inst = s_inst;

        if (rsp)       busy = 1'b0;
        else if (busy) lat_cnt--;
        if (fire) begin
            busy      = 1'b1;
            busy_addr = s_addr;
            lat_cnt   = lat;
        end

        if (!halted) begin
            if (jen) begin
`ifdef IFU_ALIGN_CHK_EN
                if ((jpc & 32'h3) != 32'h0) begin
                    halted  = 1'b1;
                    exp_mis = 1'b1;
                end else begin
                    exp_pc = jpc;
                end
`else
                exp_pc = jpc & 32'hFFFF_FFFC;
`endif
            end else if (hs) begin
                exp_pc = exp_pc + 32'd4;
                if (endf) halted = 1'b1;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        model_clear();
        do_reset();

        // zero-wait memory, decode always ready: one instruction every 3 cycles
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, 0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
            check("t1_req", s_req, (i % 3) == 0);
            if ((i % 3) == 0) check("t1_addr", s_addr, RESET_PC + 32'(4 * (i / 3)));
            check("t1_valid", s_sv, (i % 3) == 2);
            if ((i % 3) == 2) check("t1_pc", s_pc, RESET_PC + 32'(4 * (i / 3)));
        end

        // decode stall in HOLD
        cyc(1'b1, 0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("t2_addr", s_addr, 32'h8000_000C);
        cyc(1'b1, 0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            check("t2_stall_valid", s_sv, 1'b1);
            check("t2_stall_no_req", s_req, 1'b0);
            check("t2_stall_pc", s_pc, 32'h8000_000C);
            check("t2_stall_inst", s_inst, mem_word(32'h8000_000C));
        end
        cyc(1'b1, 0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("t2_release_valid", s_sv, 1'b1);
        cyc(1'b1, 1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("t2_next_req", s_req, 1'b1);
        check("t2_next_addr", s_addr, 32'h8000_0010);

        // redirect in WAIT, response one cycle later is discarded
        cyc(1'b1, 0, 1'b1, 1'b1, 32'h8000_0100, 1'b0, 1'b0);
        cyc(1'b1, 0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("t3_no_present", s_sv, 1'b0);
        cyc(1'b1, 0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("t3_no_present2", s_sv, 1'b0);
        check("t3_req", s_req, 1'b1);
        check("t3_addr", s_addr, 32'h8000_0100);
        cyc(1'b1, 0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

        // redirect in HOLD together with decode ready; target near the wrap point
        cyc(1'b1, 0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        check("t4_hold_pc", s_pc, 32'h8000_0100);
        cyc(1'b1, 0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("t4_addr", s_addr, 32'hFFFF_FFFC);
        cyc(1'b1, 0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("t4_top_pc", s_pc, 32'hFFFF_FFFC);
        cyc(1'b1, 0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("t4_wrap_req", s_req, 1'b1);
        check("t4_wrap_addr", s_addr, 32'h0);

        // end instruction accepted: permanent halt
        cyc(1'b1, 0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        check("t5_end_pc", s_pc, 32'h0);
        cyc(1'b1, 0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("t5_halt", halt, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 0, 1'b1, 1'($urandom % 2), $urandom, 1'b0, 1'b0);
            check("t5_no_req", s_req, 1'b0);
        end

        // redirect to a misaligned target
        do_reset();
        cyc(1'b0, 0, 1'b0, 1'b1, 32'h8000_0102, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
`ifdef IFU_ALIGN_CHK_EN
        check("t6_misalign", misalign, 1'b1);
        check("t6_halt", halt, 1'b1);
        check("t6_no_req", s_req, 1'b0);
`else
        check("t6_misalign_tied", misalign, 1'b0);
        check("t6_req", s_req, 1'b1);
        check("t6_addr", s_addr, 32'h8000_0100);
`endif

        // randomized traffic, reset re-asserted at arbitrary points
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int i = 0; i < 500; i++) begin
                logic [31:0] t;
                t = $urandom;
                if (($urandom % 4) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
`ifdef IFU_ALIGN_CHK_EN
                t = t & 32'hFFFF_FFFC;
`endif
                cyc(1'(($urandom % 3) != 0), int'($urandom % 4), 1'($urandom % 2),
                    1'(($urandom % 12) == 0), t, 1'b0, 1'(($urandom % 8) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
